axi_reg_bridge: RTL and testbench
=================================

Name: axi_reg_bridge

Overview:
- AXI4 slave-to-register-port bridge that sits directly upstream of the SoC controller register bank and SPI wishbone glue.
- Converts AXI4 read and write bursts into a single-beat req/we/addr/be/wdata register strobe with fixed 1-cycle read latency.
- Serialises reads and writes; one transaction is in flight at a time.
- Generates FIXED/INCR/WRAP beat addresses and AXI responses, including SLVERR for unsupported or malformed transfers.

Parameters:
ID_WIDTH, 1, width of AXI ID fields (minimum 1)
ADDR_WIDTH, 32, AXI and register address width
DATA_WIDTH, 64, data width; fixed at 64, be width is DATA_WIDTH/8

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_awid/i_awaddr/i_awlen/i_awsize/i_awburst/i_awvalid  in  ID_WIDTH/32/8/3/2/1  AXI write address
o_awready  out  1  write address accept
i_wdata/i_wstrb/i_wlast/i_wvalid  in  64/8/1/1  AXI write data
o_wready  out  1  write data accept
o_bid/o_bresp/o_bvalid  out  ID_WIDTH/2/1  write response
i_bready  in  1  response accept
i_arid/i_araddr/i_arlen/i_arsize/i_arburst/i_arvalid  in  ID_WIDTH/32/8/3/2/1  AXI read address
o_arready  out  1  read address accept
o_rid/o_rdata/o_rresp/o_rlast/o_rvalid  out  ID_WIDTH/64/2/1/1  read data
i_rready  in  1  read data accept
o_req  out  1  register access strobe, one cycle per beat
o_we  out  1  write qualifier for o_req
o_addr  out  32  beat byte address
o_be  out  8  byte enables (wstrb on writes, 8'hFF on reads)
o_wdata  out  64  write data
i_rdata  in  64  read data, valid exactly 1 cycle after o_req & !o_we

Behaviour:
- Reset: clk and rst_n are the only clock and reset; reset is synchronous, active-low.
- During and after reset, state=IDLE and o_awready=o_arready=o_wready=o_bvalid=o_rvalid=o_req=0.
- After reset, last_grant=READ, so a write wins the first tie.
- Reset mid-burst abandons the burst: no further o_req, no response is issued, and state returns to IDLE.
- FSM states: IDLE, WDATA, WRESP, RREQ, RCAP, RVALID.
- IDLE:
  - o_awready=i_awvalid & grant_w; o_arready=i_arvalid & grant_r.
  - With only one channel valid, that channel is granted.
  - With both valid, the channel not served last is granted (round-robin).
  - On the AW handshake, capture id, addr, len, size and burst, clear beat_cnt and err, then go to WDATA.
  - On the AR handshake, capture the same fields and go to RREQ.
- Error on accept: err is set at capture if size>3 or burst==2'b11 (reserved), or if burst==WRAP and len is not in {1,3,7,15}.
  - With err set, no o_req is generated for the whole burst.
  - The W beats are still consumed and the R beats are still returned, with rdata=0.
- Address generation:
  - FIXED: every beat uses the captured address.
  - INCR: next = (addr & ~((1<<size)-1)) + (1<<size), using 32-bit wrap-around arithmetic.
  - WRAP: wrap size W = (len+1)<<size; the incremented address replaces bits below log2(W) and keeps the upper bits of the start address.
  - The first beat always uses the unaligned start address.
- WDATA:
  - o_wready=1.
  - On i_wvalid, in the same cycle: o_req=!err, o_we=1, o_be=i_wstrb, o_wdata=i_wdata; then beat_cnt++ and the address advances.
  - Throughput is 1 beat/cycle.
  - Set err if i_wlast != (beat_cnt==len).
  - After beat len+1, go to WRESP; a missing or early wlast never shortens or extends the burst.
- WRESP: o_bvalid=1, o_bid=captured id, o_bresp=err?2'b10:2'b00. Hold until i_bready, then go to IDLE and set last_grant=WRITE.
- RREQ: for one cycle o_req=!err, o_we=0, o_be=8'hFF; go to RCAP.
- RCAP: register i_rdata (or 0 if err) into the r_data register; go to RVALID.
- RVALID:
  - o_rvalid=1, o_rid=id, o_rresp=err?2'b10:2'b00, o_rlast=(beat_cnt==len).
  - All R outputs stay stable until i_rready.
  - On handshake: if last, go to IDLE and set last_grant=READ; otherwise beat_cnt++, advance the address, and go to RREQ.
  - Throughput is 1 beat per 3 cycles.
- o_req is never asserted outside WDATA/RREQ; o_req never asserts twice for one beat.
- beat_cnt is 8-bit; len=255 gives 256 beats.

Test Plan:
- Single write: AW addr 0x10, len 0, size 3, INCR; W data 0x0123456789ABCDEF, strb 0xFF, wlast=1 -> one o_req/o_we with o_addr=0x10, o_be=0xFF; bresp=0, bid echoed.
- INCR read: AR addr 0x20, len 3, size 3, i_rready=1 -> o_req at addr 0x20/0x28/0x30/0x38; four R beats with rlast only on the 4th; each beat spaced 3 cycles.
- WRAP read: addr 0x38, len 3, size 3 -> beat addresses 0x38, 0x20, 0x28, 0x30.
- Arbitration: AW and AR both asserted in the same cycle twice in a row -> write served first, then read; the following tie serves write again.
- Error cases:
  - Write with wlast asserted on beat 1 of a len=2 burst -> 3 beats consumed, bresp=2'b10.
  - AR with burst 2'b11 -> zero o_req, rresp=2'b10 on all beats.
- Backpressure and reset:
  - Hold i_rready=0 for 5 cycles in RVALID -> rdata/rlast/rvalid stable, no new o_req.
  - Assert rst_n=0 mid-burst -> all valids drop next cycle; a fresh AW then completes normally.

Source files
------------

// File: rtl/axi_reg_bridge.sv
// AXI4 slave to single-beat register port bridge.
// One transaction is in flight at a time. Reads and writes are arbitrated
// round-robin. Each write beat becomes one register strobe in the same cycle
// the W beat is accepted. Each read beat becomes a strobe, then a one-cycle
// capture, then an R beat.
// Malformed bursts are still run to completion on the AXI side. They never
// touch the register port, and they complete with SLVERR.
module axi_reg_bridge #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // write address channel
    input  logic [ID_WIDTH-1:0]     i_awid,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    // write data channel
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    // write response channel
    output logic [ID_WIDTH-1:0]     o_bid,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    // read address channel
    input  logic [ID_WIDTH-1:0]     i_arid,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic [2:0]              i_arsize,
    input  logic [1:0]              i_arburst,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    // read data channel
    output logic [ID_WIDTH-1:0]     o_rid,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready,
    // register port
    output logic                    o_req,
    output logic                    o_we,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH/8-1:0] o_be,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    input  logic [DATA_WIDTH-1:0]   i_rdata
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WDATA  = 3'd1,
        WRESP  = 3'd2,
        RREQ   = 3'd3,
        RCAP   = 3'd4,
        RVALID = 3'd5
    } state_t;

    // Flags a transfer this bridge cannot execute: a size wider than the bus,
    // the reserved burst type, or a WRAP burst whose length is illegal.
    function automatic logic cfg_bad(input logic [7:0] len,
                                     input logic [2:0] size,
                                     input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size > 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // Computes the address of the next beat. INCR aligns the address, then
    // steps it. WRAP keeps the start address's bits above the wrap boundary.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [2:0]            size,
                                                        input logic [7:0]            len,
                                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] res;
        step = ONE_A << size;
        incr = (addr & ~(step - ONE_A)) + step;
        mask = ((({{(ADDR_WIDTH-8){1'b0}}, len}) + ONE_A) << size) - ONE_A;
        case (burst)
            2'b00:   res = addr;
            2'b01:   res = incr;
            2'b10:   res = (addr & ~mask) | (incr & mask);
            default: res = addr;
        endcase
        return res;
    endfunction

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [ID_WIDTH-1:0]     id_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [7:0]              len_r;
    logic [2:0]              size_r;
    logic [1:0]              burst_r;
    logic [7:0]              beat_cnt_r;
    logic                    err_r;
    logic                    last_write_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    grant_w_s;
    logic                    grant_r_s;
    logic                    aw_hs_s;
    logic                    ar_hs_s;
    logic                    last_beat_s;

    // On a tie, the grant goes to the channel that was not served last.
    assign grant_w_s   = i_awvalid & (~i_arvalid | ~last_write_r);
    assign grant_r_s   = i_arvalid & (~i_awvalid | last_write_r);
    assign aw_hs_s     = (state_r == IDLE) & grant_w_s;
    assign ar_hs_s     = (state_r == IDLE) & grant_r_s;
    assign last_beat_s = (beat_cnt_r == len_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and channel/register-port outputs.
    always_comb begin
        state_nx_s = state_r;
        o_awready  = 1'b0;
        o_arready  = 1'b0;
        o_wready   = 1'b0;
        o_bvalid   = 1'b0;
        o_rvalid   = 1'b0;
        o_req      = 1'b0;
        o_we       = 1'b0;
        o_be       = {BE_W{1'b1}};
        o_addr     = addr_r;
        o_wdata    = i_wdata;
        o_bid      = id_r;
        o_bresp    = err_r ? 2'b10 : 2'b00;
        o_rid      = id_r;
        o_rdata    = rdata_r;
        o_rresp    = err_r ? 2'b10 : 2'b00;
        o_rlast    = last_beat_s;
        if (!rst_n) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    o_awready = aw_hs_s;
                    o_arready = ar_hs_s;
                    if (aw_hs_s) begin
                        state_nx_s = WDATA;
                    end else if (ar_hs_s) begin
                        state_nx_s = RREQ;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                WDATA: begin
                    o_wready = 1'b1;
                    if (i_wvalid) begin
                        o_req      = ~err_r;
                        o_we       = 1'b1;
                        o_be       = i_wstrb;
                        state_nx_s = last_beat_s ? WRESP : WDATA;
                    end else begin
                        state_nx_s = WDATA;
                    end
                end
                WRESP: begin
                    o_bvalid = 1'b1;
                    if (i_bready) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = WRESP;
                    end
                end
                RREQ: begin
                    o_req      = ~err_r;
                    state_nx_s = RCAP;
                end
                RCAP: begin
                    state_nx_s = RVALID;
                end
                RVALID: begin
                    o_rvalid = 1'b1;
                    if (i_rready) begin
                        state_nx_s = last_beat_s ? IDLE : RREQ;
                    end else begin
                        state_nx_s = RVALID;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // Burst context, beat counting, error tracking, read capture and arbitration history.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_r         <= {ID_WIDTH{1'b0}};
            addr_r       <= {ADDR_WIDTH{1'b0}};
            len_r        <= 8'd0;
            size_r       <= 3'd0;
            burst_r      <= 2'd0;
            beat_cnt_r   <= 8'd0;
            err_r        <= 1'b0;
            last_write_r <= 1'b0;
            rdata_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (aw_hs_s) begin
                        id_r       <= i_awid;
                        addr_r     <= i_awaddr;
                        len_r      <= i_awlen;
                        size_r     <= i_awsize;
                        burst_r    <= i_awburst;
                        beat_cnt_r <= 8'd0;
                        err_r      <= cfg_bad(i_awlen, i_awsize, i_awburst);
                    end else if (ar_hs_s) begin
                        id_r       <= i_arid;
                        addr_r     <= i_araddr;
                        len_r      <= i_arlen;
                        size_r     <= i_arsize;
                        burst_r    <= i_arburst;
                        beat_cnt_r <= 8'd0;
                        err_r      <= cfg_bad(i_arlen, i_arsize, i_arburst);
                    end
                end
                WDATA: begin
                    if (i_wvalid) begin
                        beat_cnt_r <= beat_cnt_r + 8'd1;
                        addr_r     <= next_addr(addr_r, size_r, len_r, burst_r);
                        if (i_wlast != last_beat_s) begin
                            err_r <= 1'b1;
                        end
                    end
                end
                WRESP: begin
                    if (i_bready) begin
                        last_write_r <= 1'b1;
                    end
                end
                RCAP: begin
                    rdata_r <= err_r ? {DATA_WIDTH{1'b0}} : i_rdata;
                end
                RVALID: begin
                    if (i_rready) begin
                        if (last_beat_s) begin
                            last_write_r <= 1'b0;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                            addr_r     <= next_addr(addr_r, size_r, len_r, burst_r);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Scoreboard bench for axi_reg_bridge. Expected register strobes and B/R
// responses are queued as stimulus is issued. They are compared when the
// DUT produces them.
module tb_axi_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  i_awid = 1'b0, i_arid = 1'b0;
    logic [31:0] i_awaddr = 32'd0, i_araddr = 32'd0;
    logic [7:0]  i_awlen = 8'd0, i_arlen = 8'd0;
    logic [2:0]  i_awsize = 3'd0, i_arsize = 3'd0;
    logic [1:0]  i_awburst = 2'd0, i_arburst = 2'd0;
    logic        i_awvalid = 1'b0, i_arvalid = 1'b0;
    logic [63:0] i_wdata = 64'd0;
    logic [7:0]  i_wstrb = 8'd0;
    logic        i_wlast = 1'b0, i_wvalid = 1'b0;
    logic        i_bready = 1'b1, i_rready = 1'b1;
    logic [63:0] i_rdata = 64'd0;
    logic        o_awready, o_wready, o_arready, o_bvalid, o_rvalid, o_rlast;
    logic        o_req, o_we;
    logic [0:0]  o_bid, o_rid;
    logic [1:0]  o_bresp, o_rresp;
    logic [63:0] o_rdata, o_wdata;
    logic [31:0] o_addr;
    logic [7:0]  o_be;

    typedef struct {logic we; logic [31:0] addr; logic [7:0] be; logic [63:0] wdata;} req_t;
    typedef struct {logic id; logic [63:0] data; logic [1:0] resp; logic last;} r_t;
    typedef struct {logic id; logic [1:0] resp;} b_t;

    req_t exp_req[$];
    r_t   exp_r[$];
    b_t   exp_b[$];
    int   rcyc[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   r_hs = 0;

    axi_reg_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .i_awid(i_awid), .i_awaddr(i_awaddr), .i_awlen(i_awlen), .i_awsize(i_awsize),
        .i_awburst(i_awburst), .i_awvalid(i_awvalid), .o_awready(o_awready),
        .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast), .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .o_bid(o_bid), .o_bresp(o_bresp), .o_bvalid(o_bvalid), .i_bready(i_bready),
        .i_arid(i_arid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize),
        .i_arburst(i_arburst), .i_arvalid(i_arvalid), .o_arready(o_arready),
        .o_rid(o_rid), .o_rdata(o_rdata), .o_rresp(o_rresp), .o_rlast(o_rlast),
        .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_req(o_req), .o_we(o_we), .o_addr(o_addr), .o_be(o_be), .o_wdata(o_wdata),
        .i_rdata(i_rdata)
    );

    always #5 clk = ~clk;

    // Counts clock cycles for the read-beat spacing check.
    always @(posedge clk) cyc <= cyc + 1;

    // Register bank model: read data depends on the address and is valid only in the cycle after a read strobe.
    function automatic logic [63:0] bank_val(input logic [31:0] a);
        return {a ^ 32'hA5A5_5A5A, a};
    endfunction

    always @(posedge clk) i_rdata <= (o_req && !o_we) ? bank_val(o_addr) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: sampled at the falling edge, where values are stable for the coming handshake edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_req) begin
                if (exp_req.size() == 0) begin
                    check_val("req_unexpected", 64'd1, 64'd0);
                end else begin
                    req_t e;
                    e = exp_req.pop_front();
                    check_val("req_we", {63'd0, o_we}, {63'd0, e.we});
                    check_val("req_addr", {32'd0, o_addr}, {32'd0, e.addr});
                    check_val("req_be", {56'd0, o_be}, {56'd0, e.be});
                    if (e.we) check_val("req_wdata", o_wdata, e.wdata);
                end
            end
            if (o_bvalid && i_bready) begin
                if (exp_b.size() == 0) begin
                    check_val("b_unexpected", 64'd1, 64'd0);
                end else begin
                    b_t e;
                    e = exp_b.pop_front();
                    check_val("bid", {63'd0, o_bid}, {63'd0, e.id});
                    check_val("bresp", {62'd0, o_bresp}, {62'd0, e.resp});
                end
            end
            if (o_rvalid && i_rready) begin
                rcyc.push_back(cyc);
                r_hs++;
                if (exp_r.size() == 0) begin
                    check_val("r_unexpected", 64'd1, 64'd0);
                end else begin
                    r_t e;
                    e = exp_r.pop_front();
                    check_val("rid", {63'd0, o_rid}, {63'd0, e.id});
                    check_val("rdata", o_rdata, e.data);
                    check_val("rresp", {62'd0, o_rresp}, {62'd0, e.resp});
                    check_val("rlast", {63'd0, o_rlast}, {63'd0, e.last});
                end
            end
        end
    end

    task automatic exp_w(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        exp_req.push_back('{1'b1, a, be, d});
    endtask

    task automatic exp_rd(input logic [31:0] a, input logic id, input logic last);
        exp_req.push_back('{1'b0, a, 8'hFF, 64'd0});
        exp_r.push_back('{id, bank_val(a), 2'b00, last});
    endtask

    task automatic set_aw(input logic id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
        i_awid = id; i_awaddr = a; i_awlen = len; i_awsize = sz; i_awburst = bu; i_awvalid = 1'b1;
    endtask

    task automatic set_ar(input logic id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu);
        i_arid = id; i_araddr = a; i_arlen = len; i_arsize = sz; i_arburst = bu; i_arvalid = 1'b1;
    endtask

    task automatic wait_aw();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); got = o_awready;
            @(posedge clk); #1;
        end
        if (!got) check_val("aw_timeout", 64'd0, 64'd1);
        i_awvalid = 1'b0;
    endtask

    task automatic wait_ar();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); got = o_arready;
            @(posedge clk); #1;
        end
        if (!got) check_val("ar_timeout", 64'd0, 64'd1);
        i_arvalid = 1'b0;
    endtask

    task automatic w_beats(input int n, input int last_idx, input logic [63:0] seed, input logic [7:0] strb);
        for (int b = 0; b < n; b++) begin
            logic got;
            got = 1'b0;
            i_wdata = seed + 64'(b); i_wstrb = strb; i_wlast = (b == last_idx); i_wvalid = 1'b1;
            for (int k = 0; k < 50 && !got; k++) begin
                @(negedge clk); got = o_wready;
                @(posedge clk); #1;
            end
            if (!got) check_val("w_timeout", 64'd0, 64'd1);
        end
        i_wvalid = 1'b0; i_wlast = 1'b0;
    endtask

    task automatic wait_b();
        logic got;
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk); got = o_bvalid;
            @(posedge clk); #1;
        end
        if (!got) check_val("b_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_r(input int n);
        int target;
        target = r_hs + n;
        for (int k = 0; k < 200 && r_hs < target; k++) begin
            @(posedge clk); #1;
        end
        if (r_hs < target) check_val("r_timeout", 64'(r_hs), 64'(target));
    endtask

    // Full single-beat write and single-beat read helpers.
    task automatic wr1(input logic id, input logic [31:0] a, input logic [63:0] d);
        exp_w(a, 8'hFF, d);
        exp_b.push_back('{id, 2'b00});
        set_aw(id, a, 8'd0, 3'd3, 2'b01);
        wait_aw();
        w_beats(1, 0, d, 8'hFF);
        wait_b();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset: outputs must stay low even with both address channels requesting
        i_awvalid = 1'b1; i_arvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset_outs", {58'd0, o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_req}, 64'd0);
        @(posedge clk); #1;
        i_awvalid = 1'b0; i_arvalid = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;

        // two ties in a row: write wins after reset, then again after the read
        for (int t = 0; t < 2; t++) begin
            exp_w(32'h500 + 32'(t * 16), 8'hFF, 64'h1111_0000_0000_0000);
            exp_b.push_back('{1'b1, 2'b00});
            exp_rd(32'h600 + 32'(t * 16), 1'b0, 1'b1);
            set_aw(1'b1, 32'h500 + 32'(t * 16), 8'd0, 3'd3, 2'b01);
            set_ar(1'b0, 32'h600 + 32'(t * 16), 8'd0, 3'd3, 2'b01);
            @(negedge clk);
            check_val("tie_write_first", {62'd0, o_awready, o_arready}, 64'd2);
            @(posedge clk); #1;
            i_awvalid = 1'b0;
            w_beats(1, 0, 64'h1111_0000_0000_0000, 8'hFF);
            wait_b();
            wait_ar();
            wait_r(1);
        end

        // single write from the test plan
        wr1(1'b1, 32'h10, 64'h0123_4567_89AB_CDEF);

        // tie after a write: the read is granted first
        exp_rd(32'h700, 1'b1, 1'b1);
        exp_w(32'h708, 8'hFF, 64'h2222);
        exp_b.push_back('{1'b0, 2'b00});
        set_aw(1'b0, 32'h708, 8'd0, 3'd3, 2'b01);
        set_ar(1'b1, 32'h700, 8'd0, 3'd3, 2'b01);
        @(negedge clk);
        check_val("tie_read_after_write", {62'd0, o_awready, o_arready}, 64'd1);
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        wait_r(1);
        wait_aw();
        w_beats(1, 0, 64'h2222, 8'hFF);
        wait_b();

        // INCR read, 4 beats, one beat every 3 cycles
        exp_rd(32'h20, 1'b0, 1'b0); exp_rd(32'h28, 1'b0, 1'b0);
        exp_rd(32'h30, 1'b0, 1'b0); exp_rd(32'h38, 1'b0, 1'b1);
        rcyc.delete();
        set_ar(1'b0, 32'h20, 8'd3, 3'd3, 2'b01);
        wait_ar();
        wait_r(4);
        check_val("incr_beats", 64'(rcyc.size()), 64'd4);
        for (int i = 1; i < rcyc.size(); i++) check_val("r_spacing", 64'(rcyc[i] - rcyc[i-1]), 64'd3);

        // WRAP read wraps on a 32-byte boundary
        exp_rd(32'h38, 1'b1, 1'b0); exp_rd(32'h20, 1'b1, 1'b0);
        exp_rd(32'h28, 1'b1, 1'b0); exp_rd(32'h30, 1'b1, 1'b1);
        set_ar(1'b1, 32'h38, 8'd3, 3'd3, 2'b10);
        wait_ar();
        wait_r(4);

        // FIXED read repeats the start address
        exp_rd(32'h80, 1'b0, 1'b0); exp_rd(32'h80, 1'b0, 1'b1);
        set_ar(1'b0, 32'h80, 8'd1, 3'd3, 2'b00);
        wait_ar();
        wait_r(2);

        // unaligned 4-byte INCR write: the second beat is aligned
        exp_w(32'h42, 8'h3C, 64'h5000); exp_w(32'h44, 8'h3C, 64'h5001);
        exp_b.push_back('{1'b0, 2'b00});
        set_aw(1'b0, 32'h42, 8'd1, 3'd2, 2'b01);
        wait_aw();
        w_beats(2, 1, 64'h5000, 8'hFF & 8'h3C);
        wait_b();

        // early wlast on a 3-beat write: all beats consumed, no strobe after the error, SLVERR
        exp_w(32'h100, 8'hFF, 64'h7000); exp_w(32'h108, 8'hFF, 64'h7001);
        exp_b.push_back('{1'b1, 2'b10});
        set_aw(1'b1, 32'h100, 8'd2, 3'd3, 2'b01);
        wait_aw();
        w_beats(3, 1, 64'h7000, 8'hFF);
        wait_b();

        // reserved burst type: no strobes, zero data, SLVERR on every beat
        exp_r.push_back('{1'b0, 64'd0, 2'b10, 1'b0});
        exp_r.push_back('{1'b0, 64'd0, 2'b10, 1'b1});
        set_ar(1'b0, 32'h180, 8'd1, 3'd3, 2'b11);
        wait_ar();
        wait_r(2);

        // WRAP with an illegal length is also rejected
        exp_r.push_back('{1'b1, 64'd0, 2'b10, 1'b0});
        exp_r.push_back('{1'b1, 64'd0, 2'b10, 1'b0});
        exp_r.push_back('{1'b1, 64'd0, 2'b10, 1'b1});
        set_ar(1'b1, 32'h40, 8'd2, 3'd3, 2'b10);
        wait_ar();
        wait_r(3);

        // read backpressure: R outputs hold and no strobe is issued while stalled
        exp_rd(32'h400, 1'b0, 1'b0); exp_rd(32'h408, 1'b0, 1'b1);
        i_rready = 1'b0;
        set_ar(1'b0, 32'h400, 8'd1, 3'd3, 2'b01);
        wait_ar();
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk); got = o_rvalid;
                if (!got) begin @(posedge clk); #1; end
            end
            if (!got) check_val("bp_rvalid_timeout", 64'd0, 64'd1);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("bp_rvalid", {63'd0, o_rvalid}, 64'd1);
            check_val("bp_rdata", o_rdata, bank_val(32'h400));
            check_val("bp_rlast", {63'd0, o_rlast}, 64'd0);
            check_val("bp_no_req", {63'd0, o_req}, 64'd0);
            @(posedge clk); #1;
        end
        i_rready = 1'b1;
        wait_r(2);

        // reset in the middle of a write burst abandons it
        exp_w(32'h200, 8'hFF, 64'h9000);
        set_aw(1'b0, 32'h200, 8'd3, 3'd3, 2'b01);
        wait_aw();
        w_beats(1, 99, 64'h9000, 8'hFF);
        i_wvalid = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("rst_mid_outs", {58'd0, o_awready, o_arready, o_wready, o_bvalid, o_rvalid, o_req}, 64'd0);
        @(posedge clk); #1;
        i_wvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wr1(1'b1, 32'h300, 64'hCAFE_F00D_0000_0001);

        repeat (6) @(posedge clk);
        #1;
        check_val("req_queue_empty", 64'(exp_req.size()), 64'd0);
        check_val("b_queue_empty", 64'(exp_b.size()), 64'd0);
        check_val("r_queue_empty", 64'(exp_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
